issue_window: RTL and testbench
===============================

ISSUE_WINDOW -- requirements
Module: issue_window

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width in bits; opcode is bits [IW-1:IW-4].
REQ-002 SHALL have parameter SW, default 8, width of stall counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_valid  input  1  fetch offers a 4-instruction bundle.
REQ-006 SHALL have port fetch_instr1..fetch_instr4  input  IW each  offered bundle, slot 1 oldest.
REQ-007 SHALL have port fetch_slot_valid  input  4  per-slot validity of offered bundle (bit0 = slot 1).
REQ-008 SHALL have port fetch_ready  output  1  window accepts a bundle this cycle.
REQ-009 SHALL have port flush  input  1  discard all held slots.
REQ-010 SHALL have port op1..op4  output  4 each  opcode of held slot N, to the load/store check.
REQ-011 SHALL have port ins1_history..ins4_history  output  1 each  slot N holds a not-yet-issued instruction.
REQ-012 SHALL have port ins1_out..ins4_out  input  1 each  slot N issues this cycle (from load/store check).
REQ-013 SHALL have port instr1..instr4  output  IW each  held instruction words, to issue/ALU routing.
REQ-014 SHALL have port stall_cnt  output  SW  consecutive cycles current bundle has been held with slots pending.
REQ-015 SHALL have port stuck  output  1  stall_cnt saturated.

Function
REQ-016 SHALL hold state: slot valid v[4], instruction registers, FSM state {EMPTY, HOLD}, stall_cnt.
REQ-017 SHALL drive insN_history = v[N]; opN = instrN[IW-1:IW-4]; outputs are registered state only (no fetch-to-history path).
REQ-018 SHALL treat issue bit as effective only when insN_out=1 and v[N]=1; insN_out on an invalid slot is ignored.
REQ-019 SHALL compute remaining = v & ~effective_issue each cycle.
REQ-020 SHALL assert fetch_ready combinationally when flush=0 and remaining==4'b0000 (covers EMPTY and last-slots-issuing-now).
REQ-021 SHALL, on fetch_valid & fetch_ready, load all four instruction registers and set v = fetch_slot_valid next cycle.
REQ-022 SHALL, when fetch_valid & fetch_ready with fetch_slot_valid==0, stay/go EMPTY (bundle dropped, v=0).
REQ-023 SHALL otherwise set v = remaining next cycle; instruction registers of non-issued slots unchanged (no compaction, no per-slot refill).
REQ-024 SHALL FSM: EMPTY->HOLD when v_next!=0; HOLD->EMPTY when v_next==0; state equals (v!=0).
REQ-025 SHALL give flush priority over issue and fetch: next v=0, state EMPTY, stall_cnt=0, fetch_ready=0 that cycle, no bundle accepted.
REQ-026 SHALL increment stall_cnt (saturating at 2^SW-1) in cycles where state=HOLD and effective_issue==0; reset to 0 on any effective issue, on new bundle load, or in EMPTY.
REQ-027 SHALL assert stuck = (stall_cnt == 2^SW-1); cleared with stall_cnt.
REQ-028 SHALL accept a new bundle in the same cycle the final pending slots issue (zero-bubble back-to-back).
REQ-029 SHALL not alter instruction registers when fetch_valid=1 and fetch_ready=0.

Reset
REQ-030 SHALL on rst_n=0, asynchronously: v=0, state EMPTY, stall_cnt=0, stuck=0, instruction registers 0, so all history=0, op=0, instr=0.
REQ-031 SHALL assert fetch_ready in first cycle after rst_n deasserts (flush=0).
REQ-032 SHALL, on reset mid-bundle, discard pending slots with no issue of them afterward.

Verification
REQ-033 SHALL test: reset, offer bundle ops {0001,0010,0001,0100}, slot_valid 1111 -> next cycle history=1111, op1..4 match, fetch_ready=0.
REQ-034 SHALL test: history=1111, ins_out=1100 -> next history=0011, instr3/4 unchanged; then ins_out=0011 with fetch_valid=1 -> fetch_ready=1 same cycle, new bundle held next cycle.
REQ-035 SHALL test: ins_out=1111 while v=0101 -> v becomes 0000 (bits for invalid slots ignored), state EMPTY.
REQ-036 SHALL test: flush=1 with fetch_valid=1 and ins_out=1111 -> fetch_ready=0, next history=0000, stall_cnt=0.
REQ-037 SHALL test: SW=8, hold bundle with ins_out=0000 for 300 cycles -> stall_cnt reaches 255 after 255 cycles and stays, stuck=1; one effective issue -> stall_cnt=0, stuck=0.
REQ-038 SHALL test: rst_n pulsed low asynchronously mid-bundle (between edges) -> history=0000 immediately, fetch_ready=1 after release.

Source files
------------

// File: rtl/issue_window_if.sv
// rtl/issue_window_if.sv - fetch-to-issue-window bundle handshake
interface issue_window_if #(
    parameter int IW = 16
);
    logic          fetch_valid;
    logic [IW-1:0] fetch_instr1;
    logic [IW-1:0] fetch_instr2;
    logic [IW-1:0] fetch_instr3;
    logic [IW-1:0] fetch_instr4;
    logic [3:0]    fetch_slot_valid;
    logic          fetch_ready;

    modport master (
        output fetch_valid,
        output fetch_instr1,
        output fetch_instr2,
        output fetch_instr3,
        output fetch_instr4,
        output fetch_slot_valid,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_instr1,
        input  fetch_instr2,
        input  fetch_instr3,
        input  fetch_instr4,
        input  fetch_slot_valid,
        output fetch_ready
    );
endinterface

// File: rtl/issue_window.sv
// rtl/issue_window.sv - four-slot issue window holding one fetch bundle until every slot issues
module issue_window #(
    parameter int IW = 16,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    issue_window_if.slave fetch,
    input  logic          flush,
    output logic [3:0]    op1,
    output logic [3:0]    op2,
    output logic [3:0]    op3,
    output logic [3:0]    op4,
    output logic          ins1_history,
    output logic          ins2_history,
    output logic          ins3_history,
    output logic          ins4_history,
    input  logic          ins1_out,
    input  logic          ins2_out,
    input  logic          ins3_out,
    input  logic          ins4_out,
    output logic [IW-1:0] instr1,
    output logic [IW-1:0] instr2,
    output logic [IW-1:0] instr3,
    output logic [IW-1:0] instr4,
    output logic [SW-1:0] stall_cnt,
    output logic          stuck
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam logic [SW-1:0] STALL_MAX = '1;

    state_e        state_q, state_d;
    logic [3:0]    v_q, v_d;
    logic [IW-1:0] instr_q [4];
    logic [IW-1:0] instr_d [4];
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    logic [3:0]    ins_out;
    logic [3:0]    eff_issue;
    logic [3:0]    remaining;
    logic          ready;
    logic          accept;

    assign ins_out   = {ins4_out, ins3_out, ins2_out, ins1_out};
    // Issue requests against empty slots are meaningless and must not count as progress.
    assign eff_issue = ins_out & v_q;
    assign remaining = v_q & ~eff_issue;
    assign ready     = !flush && (remaining == 4'b0000);
    assign accept    = fetch.fetch_valid && ready;

    assign fetch.fetch_ready = ready;

    always_comb begin
        v_d         = remaining;
        instr_d     = instr_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            v_d = 4'b0000;
        end else if (accept) begin
            v_d        = fetch.fetch_slot_valid;
            instr_d[0] = fetch.fetch_instr1;
            instr_d[1] = fetch.fetch_instr2;
            instr_d[2] = fetch.fetch_instr3;
            instr_d[3] = fetch.fetch_instr4;
        end

        state_d = (v_d != 4'b0000) ? ST_HOLD : ST_EMPTY;

        // Counts only fully blocked cycles; any forward progress restarts it.
        if (flush || accept || (state_q == ST_EMPTY) || (eff_issue != 4'b0000)) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            v_q         <= 4'b0000;
            stall_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
            instr_q     <= instr_d;
        end
    end

    assign ins1_history = v_q[0];
    assign ins2_history = v_q[1];
    assign ins3_history = v_q[2];
    assign ins4_history = v_q[3];

    assign instr1 = instr_q[0];
    assign instr2 = instr_q[1];
    assign instr3 = instr_q[2];
    assign instr4 = instr_q[3];

    assign op1 = instr_q[0][IW-1:IW-4];
    assign op2 = instr_q[1][IW-1:IW-4];
    assign op3 = instr_q[2][IW-1:IW-4];
    assign op4 = instr_q[3][IW-1:IW-4];

    assign stall_cnt = stall_cnt_q;
    assign stuck     = (stall_cnt_q == STALL_MAX);

endmodule

// File: tb/tb_issue_window.sv
// tb/tb_issue_window.sv - scoreboard bench for issue_window
module tb_issue_window;

    localparam int IW = 16;
    localparam int SW = 8;

    logic clk;
    logic rst_n;
    logic flush;
    logic [3:0] op1, op2, op3, op4;
    logic ins1_history, ins2_history, ins3_history, ins4_history;
    logic ins1_out, ins2_out, ins3_out, ins4_out;
    logic [IW-1:0] instr1, instr2, instr3, instr4;
    logic [SW-1:0] stall_cnt;
    logic stuck;

    issue_window_if #(.IW(IW)) fif ();

    issue_window #(.IW(IW), .SW(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch        (fif),
        .flush        (flush),
        .op1          (op1),
        .op2          (op2),
        .op3          (op3),
        .op4          (op4),
        .ins1_history (ins1_history),
        .ins2_history (ins2_history),
        .ins3_history (ins3_history),
        .ins4_history (ins4_history),
        .ins1_out     (ins1_out),
        .ins2_out     (ins2_out),
        .ins3_out     (ins3_out),
        .ins4_out     (ins4_out),
        .instr1       (instr1),
        .instr2       (instr2),
        .instr3       (instr3),
        .instr4       (instr4),
        .stall_cnt    (stall_cnt),
        .stuck        (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  hist;
        logic        fr;
        bit          chk_ops;
        logic [15:0] ops;
        bit          chk_instr;
        logic [63:0] instrs;
        bit          chk_stall;
        logic [7:0]  stall;
        logic        stuck;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Bundles packed slot4..slot1; opcode is the top nibble of each word.
    localparam logic [63:0] BA     = {16'h4abc, 16'h1789, 16'h2456, 16'h1123};
    localparam logic [15:0] BA_OPS = {4'h4, 4'h1, 4'h2, 4'h1};
    localparam logic [63:0] BE     = {16'h8ddd, 16'h7ccc, 16'h6bbb, 16'h5aaa};
    localparam logic [15:0] BE_OPS = {4'h8, 4'h7, 4'h6, 4'h5};

    function automatic exp_t mk(string name, logic [3:0] hist, logic fr);
        exp_t e;
        e.name      = name;
        e.hist      = hist;
        e.fr        = fr;
        e.chk_ops   = 1'b0;
        e.ops       = '0;
        e.chk_instr = 1'b0;
        e.instrs    = '0;
        e.chk_stall = 1'b0;
        e.stall     = '0;
        e.stuck     = 1'b0;
        return e;
    endfunction

    task automatic chk(string name, string field, logic [63:0] act, logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s.%s: got %0h expected %0h", name, field, act, expv);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "history", {60'b0, ins4_history, ins3_history, ins2_history, ins1_history}, {60'b0, e.hist});
            chk(e.name, "fetch_ready", {63'b0, fif.fetch_ready}, {63'b0, e.fr});
            if (e.chk_ops)
                chk(e.name, "ops", {48'b0, op4, op3, op2, op1}, {48'b0, e.ops});
            if (e.chk_instr)
                chk(e.name, "instrs", {instr4, instr3, instr2, instr1}, e.instrs);
            if (e.chk_stall) begin
                chk(e.name, "stall_cnt", {56'b0, stall_cnt}, {56'b0, e.stall});
                chk(e.name, "stuck", {63'b0, stuck}, {63'b0, e.stuck});
            end
        end
    end

    task automatic drive(bit fv, logic [3:0] sv, logic [63:0] bundle, bit fl, logic [3:0] ins);
        fif.fetch_valid      = fv;
        fif.fetch_slot_valid = sv;
        fif.fetch_instr1     = bundle[15:0];
        fif.fetch_instr2     = bundle[31:16];
        fif.fetch_instr3     = bundle[47:32];
        fif.fetch_instr4     = bundle[63:48];
        flush                = fl;
        {ins4_out, ins3_out, ins2_out, ins1_out} = ins;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0000);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        e = mk("reset", 4'b0000, 1'b1);
        e.chk_ops = 1; e.chk_instr = 1; e.chk_stall = 1;
        sb.push_back(e);
        #5 rst_n = 1'b1;
        advance();

        drive(1'b1, 4'b1111, BA, 1'b0, 4'b0000);
        e = mk("after_reset", 4'b0000, 1'b1);
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b1111, BE, 1'b0, 4'b0000);
        e = mk("load", 4'b1111, 1'b0);
        e.chk_ops = 1; e.ops = BA_OPS; e.chk_instr = 1; e.instrs = BA; e.chk_stall = 1;
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b1111, BE, 1'b0, 4'b0011);
        e = mk("issue_s12", 4'b1111, 1'b0);
        e.chk_instr = 1; e.instrs = BA; e.chk_stall = 1; e.stall = 8'd1;
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b0101, BE, 1'b0, 4'b1100);
        e = mk("last_issue_refill", 4'b1100, 1'b1);
        e.chk_instr = 1; e.instrs = BA; e.chk_stall = 1;
        sb.push_back(e);
        advance();

        drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b1111);
        e = mk("held_0101", 4'b0101, 1'b1);
        e.chk_ops = 1; e.ops = BE_OPS; e.chk_instr = 1; e.instrs = BE; e.chk_stall = 1;
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b0000, BA, 1'b0, 4'b0000);
        e = mk("invalid_bits_ignored", 4'b0000, 1'b1);
        e.chk_stall = 1;
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b1111, BA, 1'b0, 4'b0000);
        e = mk("empty_bundle_dropped", 4'b0000, 1'b1);
        e.chk_instr = 1; e.instrs = BA; e.chk_stall = 1;
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b1111, BE, 1'b1, 4'b1111);
        e = mk("flush_cycle", 4'b1111, 1'b0);
        e.chk_instr = 1; e.instrs = BA;
        sb.push_back(e);
        advance();

        drive(1'b1, 4'b1111, BA, 1'b0, 4'b0000);
        e = mk("after_flush", 4'b0000, 1'b1);
        e.chk_instr = 1; e.instrs = BA; e.chk_stall = 1;
        sb.push_back(e);
        advance();

        idle();
        e = mk("stall_start", 4'b1111, 1'b0);
        e.chk_stall = 1;
        sb.push_back(e);
        advance();

        for (int k = 1; k <= 300; k++) begin
            idle();
            if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256 || k == 300) begin
                e = mk($sformatf("stall_k%0d", k), 4'b1111, 1'b0);
                e.chk_stall = 1;
                e.stall = (k >= 255) ? 8'd255 : 8'(k);
                e.stuck = (k >= 255);
                sb.push_back(e);
            end
            advance();
        end

        drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b0010);
        e = mk("stuck_then_issue", 4'b1111, 1'b0);
        e.chk_stall = 1; e.stall = 8'd255; e.stuck = 1'b1;
        sb.push_back(e);
        advance();

        idle();
        e = mk("stall_cleared", 4'b1101, 1'b0);
        e.chk_stall = 1;
        sb.push_back(e);
        advance();

        idle();
        #1 rst_n = 1'b0;
        e = mk("async_reset", 4'b0000, 1'b1);
        e.chk_ops = 1; e.chk_instr = 1; e.chk_stall = 1;
        sb.push_back(e);
        #4 rst_n = 1'b1;
        advance();

        drive(1'b0, 4'b0000, 64'h0, 1'b0, 4'b1111);
        e = mk("post_reset_ready", 4'b0000, 1'b1);
        e.chk_stall = 1;
        sb.push_back(e);
        advance();

        idle();
        e = mk("post_reset_no_issue", 4'b0000, 1'b1);
        e.chk_instr = 1; e.chk_stall = 1;
        sb.push_back(e);
        advance();

        repeat (3) @(posedge clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
